// File: rtl/sprite_loader.sv
// sprite_loader: loads a 2-bit-per-pixel sprite image from a byte stream and
// serves combinational pixel reads.
//
// Parameters:
//   SPRITE_W - sprite width in pixels (multiple of 4)
//   SPRITE_H - sprite height in pixels
// Ports:
//   clk         - clock, all state on rising edge
//   rst_n       - asynchronous active-low reset
//   start       - single-cycle request to begin a load (honoured in idle only)
//   abort       - cancels a load in progress
//   in_data     - packed pixel byte, [7:6] is the leftmost pixel
//   in_valid    - in_data valid
//   in_ready    - byte accepted this cycle when in_valid is also high
//   horz, vert  - sprite-relative read column / row
//   draw_sprite - colour code at (horz, vert), 00 = transparent
//   busy        - load in progress
//   loaded      - a complete sprite image is held
//   done        - one-cycle pulse on load completion
module sprite_loader #(
  parameter int unsigned SPRITE_W = 32,
  parameter int unsigned SPRITE_H = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] horz,
  input  logic [9:0] vert,
  output logic [1:0] draw_sprite,
  output logic       busy,
  output logic       loaded,
  output logic       done
);

  localparam int unsigned Total = SPRITE_W * SPRITE_H / 4;
  localparam int unsigned AddrW = (Total > 1) ? $clog2(Total) : 1;
  localparam logic [AddrW-1:0] LastByte = AddrW'(Total - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] cnt_q, cnt_d;
  logic             loaded_q, loaded_d;
  logic             wr_en;

  // One byte holds four horizontally adjacent pixels; storage is not reset.
  logic [7:0] mem [Total];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    wr_en    = 1'b0;
    case (state_q)
      StIdle: begin
        // start beats a simultaneous abort; abort has no meaning here.
        if (start) begin
          state_d  = StLoad;
          cnt_d    = '0;
          loaded_d = 1'b0;
        end
      end
      StLoad: begin
        // abort suppresses the write, even on the final byte.
        if (abort) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (in_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastByte) begin
            state_d  = StDone;
            loaded_d = 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt_q] <= in_data;
  end

  assign in_ready = (state_q == StLoad);
  assign busy     = (state_q == StLoad);
  assign done     = (state_q == StDone);
  assign loaded   = loaded_q;

  logic [31:0] pix_idx;
  logic [7:0]  rd_byte;
  logic [1:0]  pix;

  always_comb begin
    pix_idx = 32'(vert) * SPRITE_W + 32'(horz);
    rd_byte = mem[pix_idx[AddrW+1:2]];
    case (pix_idx[1:0])
      2'd0:    pix = rd_byte[7:6];
      2'd1:    pix = rd_byte[5:4];
      2'd2:    pix = rd_byte[3:2];
      default: pix = rd_byte[1:0];
    endcase
    draw_sprite = 2'b00;
    // Out-of-range, not-yet-loaded or uninitialised pixels read as transparent.
    if (loaded_q && (32'(horz) < SPRITE_W) && (32'(vert) < SPRITE_H) &&
        ((^pix) !== 1'bx)) begin
      draw_sprite = pix;
    end
  end

endmodule

// File: tb/tb_sprite_loader.sv
module tb_sprite_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] horz, vert;
  logic [1:0] draw_sprite;
  logic       busy, loaded, done;

  int tests = 0;
  int fails = 0;
  int done_pulses = 0;

  sprite_loader #(.SPRITE_W(32), .SPRITE_H(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .horz       (horz),
    .vert       (vert),
    .draw_sprite(draw_sprite),
    .busy       (busy),
    .loaded     (loaded),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_pulses++;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic [1:0] exp;
  } rd_vec_t;

  rd_vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic with_abort);
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  // pattern 0: byte N = N[7:0]; otherwise every byte is cval. gaps inserts an
  // idle cycle carrying 0xFF (must not be written) before each byte.
  task automatic stream(input int n, input int pattern, input logic [7:0] cval, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = 8'hFF;
        tick();
      end
      in_valid = 1'b1;
      in_data  = (pattern == 0) ? i[7:0] : cval;
      tick();
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic read_table(input string tag);
    for (int i = 0; i < 15; i++) begin
      horz = vecs[i].h;
      vert = vecs[i].v;
      #1;
      check($sformatf("%s read(%0d,%0d)", tag, vecs[i].h, vecs[i].v),
            32'(draw_sprite), 32'(vecs[i].exp));
    end
  endtask

  initial begin
    // Expected pixels for an image where byte N = N[7:0]; idx = v*32 + h.
    vecs[0]  = '{10'd0,    10'd0,    2'b00};  // byte 0
    vecs[1]  = '{10'd1,    10'd0,    2'b00};
    vecs[2]  = '{10'd2,    10'd0,    2'b00};
    vecs[3]  = '{10'd3,    10'd0,    2'b00};
    vecs[4]  = '{10'd4,    10'd0,    2'b00};  // byte 1 = 0x01, pixel 0
    vecs[5]  = '{10'd7,    10'd0,    2'b01};  // byte 1, pixel 3
    vecs[6]  = '{10'd31,   10'd31,   2'b11};  // byte 255, pixel 3
    vecs[7]  = '{10'd28,   10'd31,   2'b11};  // byte 255, pixel 0
    vecs[8]  = '{10'd6,    10'd1,    2'b10};  // byte 9 = 0x09, pixel 2
    vecs[9]  = '{10'd7,    10'd1,    2'b01};  // byte 9, pixel 3
    vecs[10] = '{10'd1,    10'd2,    2'b01};  // byte 16 = 0x10, pixel 1
    vecs[11] = '{10'd20,   10'd10,   2'b01};  // byte 85 = 0x55, pixel 0
    vecs[12] = '{10'd32,   10'd0,    2'b00};  // column out of range
    vecs[13] = '{10'd0,    10'd40,   2'b00};  // row out of range
    vecs[14] = '{10'd1023, 10'd1023, 2'b00};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; horz = 10'd5; vert = 10'd5;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("reset draw(5,5)", 32'(draw_sprite), 32'd0);
    check("reset loaded", 32'(loaded), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);

    // Abort in idle does nothing.
    abort = 1'b1; tick(); abort = 1'b0;
    check("idle abort busy", 32'(busy), 32'd0);

    // Back-to-back full load.
    pulse_start(1'b0);
    check("load in_ready", 32'(in_ready), 32'd1);
    check("load busy", 32'(busy), 32'd1);
    stream(255, 0, 8'h00, 1'b0);
    check("no done before last", 32'(done_pulses), 32'd0);
    check("loaded low mid-load", 32'(loaded), 32'd0);
    stream(1, 1, 8'hFF, 1'b0);  // byte 255 = 0xFF
    check("done after last", 32'(done), 32'd1);
    check("done busy", 32'(busy), 32'd0);
    check("done in_ready", 32'(in_ready), 32'd0);
    check("done loaded", 32'(loaded), 32'd1);
    // Start in the DONE cycle is ignored.
    pulse_start(1'b0);
    check("post-done done", 32'(done), 32'd0);
    check("post-done busy", 32'(busy), 32'd0);
    check("post-done loaded", 32'(loaded), 32'd1);
    tick();
    check("start-in-done ignored", 32'(busy), 32'd0);
    check("done pulse count", 32'(done_pulses), 32'd1);
    read_table("b2b");

    // Gapped load, entered with start+abort together.
    pulse_start(1'b1);
    check("start beats abort", 32'(busy), 32'd1);
    check("start clears loaded", 32'(loaded), 32'd0);
    stream(255, 0, 8'h00, 1'b1);
    check("gapped no early done", 32'(done_pulses), 32'd1);
    stream(1, 1, 8'hFF, 1'b1);
    check("gapped done", 32'(done), 32'd1);
    tick();
    check("gapped done count", 32'(done_pulses), 32'd2);
    read_table("gap");

    // Abort after 99 bytes, coincident with byte 100.
    pulse_start(1'b0);
    stream(99, 1, 8'hFF, 1'b0);
    in_valid = 1'b1; in_data = 8'hFF; abort = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort loaded", 32'(loaded), 32'd0);
    horz = 10'd0; vert = 10'd0; #1;
    check("abort read(0,0)", 32'(draw_sprite), 32'd0);
    horz = 10'd31; vert = 10'd31; #1;
    check("abort read(31,31)", 32'(draw_sprite), 32'd0);
    tick();
    check("abort no done", 32'(done_pulses), 32'd2);

    // Abort coincident with the final byte wins.
    pulse_start(1'b0);
    stream(255, 1, 8'h55, 1'b0);
    in_valid = 1'b1; in_data = 8'h55; abort = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    check("last-byte abort done", 32'(done), 32'd0);
    check("last-byte abort loaded", 32'(loaded), 32'd0);
    check("last-byte abort busy", 32'(busy), 32'd0);

    // Full 0xAA load: every in-range pixel reads 10.
    pulse_start(1'b0);
    stream(256, 1, 8'hAA, 1'b0);
    tick();
    for (int v = 0; v < 32; v++) begin
      for (int h = 0; h < 32; h++) begin
        horz = 10'(h); vert = 10'(v); #1;
        check($sformatf("AA read(%0d,%0d)", h, v), 32'(draw_sprite), 32'd2);
      end
    end

    // Reset after byte 50: outputs drop without a clock edge.
    pulse_start(1'b0);
    stream(50, 1, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst in_ready", 32'(in_ready), 32'd0);
    check("async rst loaded", 32'(loaded), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    // Fresh load must land at byte 0 onwards.
    pulse_start(1'b0);
    stream(255, 0, 8'h00, 1'b0);
    stream(1, 1, 8'hFF, 1'b0);
    check("reload done", 32'(done), 32'd1);
    tick();
    read_table("reload");

    // Async reset in idle hides a loaded image immediately.
    horz = 10'd7; vert = 10'd0;
    #1;
    check("pre-rst read(7,0)", 32'(draw_sprite), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst read(7,0)", 32'(draw_sprite), 32'd0);
    check("rst loaded", 32'(loaded), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
